// File: rtl/multdiv_seq_ctrl.sv
// Sequential 32-bit signed multiply (radix-2 Booth) / divide (restoring) on a shared CLA.
// Define MULTDIV_REMAINDER_EN to add the signed data_remainder output and the D_FIXR state.
module multdiv_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic [1:0]       add_cout,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef MULTDIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        M_ITER,
        M_FIN,
        D_NEGA,
        D_NEGB,
        D_ITER,
        D_FIX,
`ifdef MULTDIV_REMAINDER_EN
        D_FIXR,
`endif
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   res_pend_q, res_pend_d;
    logic               exc_pend_q, exc_pend_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0]   rem_pend_q, rem_pend_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
`endif

    logic               last_iter;
    logic               sum_sign;
    logic [WIDTH-1:0]   r_shift;
    logic               neg_q;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    // True sign of the 33-bit Booth partial sum: MSB corrected by signed overflow.
    assign sum_sign  = add_sum[WIDTH-1] ^ add_cout[1] ^ add_cout[0];
    assign r_shift   = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign neg_q     = sa_q ^ sb_q;

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
`ifdef MULTDIV_REMAINDER_EN
    assign data_remainder = rem_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        res_pend_d = res_pend_q;
        exc_pend_d = exc_pend_q;
        res_d      = res_q;
        exc_d      = exc_q;
        rdy_d      = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
        rem_pend_d = rem_pend_q;
        rem_d      = rem_q;
`endif
        add_x      = '0;
        add_y      = '0;
        add_cin    = 1'b0;

        case (state_q)
            M_ITER: begin
                add_x = a_q;
                case ({q_q[0], qm1_q})
                    2'b01: add_y = m_q;
                    2'b10: begin
                        add_y   = ~m_q;
                        add_cin = 1'b1;
                    end
                    default: add_y = '0;
                endcase
                a_d   = {sum_sign, add_sum[WIDTH-1:1]};
                q_d   = {add_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = M_FIN;
                    cnt_d   = '0;
                end
            end
            M_FIN: begin
                res_d   = q_q;
                exc_d   = (a_q != {WIDTH{q_q[WIDTH-1]}});
                rdy_d   = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
                rem_d   = '0;
`endif
                state_d = IDLE;
            end
            D_NEGA: begin
                add_y   = ~q_q;
                add_cin = 1'b1;
                if (sa_q) q_d = add_sum;
                state_d = D_NEGB;
            end
            D_NEGB: begin
                add_y   = ~m_q;
                add_cin = 1'b1;
                if (sb_q) m_d = add_sum;
                a_d     = '0;
                cnt_d   = '0;
                state_d = D_ITER;
            end
            D_ITER: begin
                add_x   = r_shift;
                add_y   = ~m_q;
                add_cin = 1'b1;
                // Carry out of the subtract means no borrow: divisor fits.
                if (add_cout[1]) begin
                    a_d = add_sum;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = r_shift;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = D_FIX;
                    cnt_d   = '0;
                end
            end
            D_FIX: begin
                add_y      = ~q_q;
                add_cin    = 1'b1;
                exc_pend_d = ~neg_q & q_q[WIDTH-1];
                if (~neg_q & q_q[WIDTH-1]) res_pend_d = '0;
                else if (neg_q)            res_pend_d = add_sum;
                else                       res_pend_d = q_q;
`ifdef MULTDIV_REMAINDER_EN
                state_d    = D_FIXR;
`else
                state_d    = DONE;
`endif
            end
`ifdef MULTDIV_REMAINDER_EN
            D_FIXR: begin
                add_y      = ~a_q;
                add_cin    = 1'b1;
                rem_pend_d = sa_q ? add_sum : a_q;
                state_d    = DONE;
            end
`endif
            DONE: begin
                res_d   = res_pend_q;
                exc_d   = exc_pend_q;
`ifdef MULTDIV_REMAINDER_EN
                rem_d   = rem_pend_q;
`endif
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new start aborts whatever is in flight; MULT has priority.
        if (ctrl_MULT) begin
            state_d = M_ITER;
            cnt_d   = '0;
            a_d     = '0;
            q_d     = data_operandB;
            qm1_d   = 1'b0;
            m_d     = data_operandA;
            rdy_d   = 1'b0;
        end else if (ctrl_DIV) begin
            cnt_d = '0;
            rdy_d = 1'b0;
            if (data_operandB == '0) begin
                state_d    = DONE;
                res_pend_d = '0;
                exc_pend_d = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
                rem_pend_d = '0;
`endif
            end else begin
                state_d = D_NEGA;
                q_d     = data_operandA;
                m_d     = data_operandB;
                sa_d    = data_operandA[WIDTH-1];
                sb_d    = data_operandB[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            res_pend_q <= '0;
            exc_pend_q <= 1'b0;
            res_q      <= '0;
            exc_q      <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            rem_pend_q <= '0;
            rem_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            res_pend_q <= res_pend_d;
            exc_pend_q <= exc_pend_d;
            res_q      <= res_d;
            exc_q      <= exc_d;
            rdy_q      <= rdy_d;
`ifdef MULTDIV_REMAINDER_EN
            rem_pend_q <= rem_pend_d;
            rem_q      <= rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Directed bench for multdiv_seq_ctrl with a behavioural model of the shared 32-bit CLA.
// Latencies are edges from the start edge to the edge after which RDY is seen high.
module tb_multdiv_seq_ctrl;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [31:0] add_sum;
    logic [1:0]  add_cout;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef MULTDIV_REMAINDER_EN
    logic [31:0] data_remainder;
    localparam int DIV_LAT = 37;
`else
    localparam int DIV_LAT = 36;
`endif
    localparam int MUL_LAT = 33;

    int errors = 0;
    int checks = 0;

    multdiv_seq_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .add_x          (add_x),
        .add_y          (add_y),
        .add_cin        (add_cin),
        .add_sum        (add_sum),
        .add_cout       (add_cout),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
`ifdef MULTDIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared adder: sum, {carry out of bit 31, carry into bit 31}.
    logic [32:0] s33;
    logic [31:0] s31;
    always_comb begin
        s33      = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
        s31      = {1'b0, add_x[30:0]} + {1'b0, add_y[30:0]} + {31'd0, add_cin};
        add_sum  = s33[31:0];
        add_cout = {s33[32], s31[31]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = ~is_div;
        ctrl_DIV      = is_div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = ~a ^ 32'h5A5A_1234;
        data_operandB = b + 32'd17;
    endtask

    task automatic wait_rdy(output int lat, output int pulses, input int bound);
        lat    = 0;
        pulses = 0;
        for (int n = 1; n <= bound; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
    endtask

    task automatic run_op(input string tag, input bit is_div,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_exc, input logic [31:0] exp_rem);
        int lat;
        int pulses;
        start(is_div, a, b);
        lat = 0;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
`ifdef MULTDIV_REMAINDER_EN
        check({tag, "_rem"}, data_remainder, exp_rem);
`else
        if (exp_rem != exp_rem + 32'd1) begin end
`endif
        @(posedge clock);
        #1;
        check({tag, "_pulse"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, "_hold"}, data_result, exp_res);
        pulses = 0;
        lat    = 0;
    endtask

    initial begin
        int lat;
        int pulses;
        int pre;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_res", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_addx", add_x, 32'd0);
        check("rst_addy", add_y, 32'd0);
        check("rst_cin", {31'd0, add_cin}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul_7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFEB, 1'b0, 32'd0);
        run_op("mul_ovf16", 1'b0, 32'h0001_0000, 32'h0001_0000, MUL_LAT, 32'd0, 1'b1, 32'd0);
        run_op("mul_min1", 1'b0, 32'h8000_0000, 32'd1, MUL_LAT, 32'h8000_0000, 1'b0, 32'd0);
        run_op("mul_m5m6", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, MUL_LAT, 32'd30, 1'b0, 32'd0);
        run_op("mul_max2", 1'b0, 32'h7FFF_FFFF, 32'd2, MUL_LAT, 32'hFFFF_FFFE, 1'b1, 32'd0);
        run_op("mul_minm1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, MUL_LAT, 32'h8000_0000, 1'b1, 32'd0);
        run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, DIV_LAT, 32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFFE);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, DIV_LAT, 32'd14, 1'b0, 32'd2);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'hFFFF_FFFD, 1'b0, 32'd1);
        run_op("div_min_1", 1'b1, 32'h8000_0000, 32'd1, DIV_LAT, 32'h8000_0000, 1'b0, 32'd0);
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 1, 32'd0, 1'b1, 32'd0);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 1'b1, 32'd0);
        run_op("mul_after", 1'b0, 32'd6, 32'd7, MUL_LAT, 32'd42, 1'b0, 32'd0);

        // DIV restart at edge 10 of a MULT: only the divide reports.
        start(1'b0, 32'd1000, 32'd1000);
        wait_rdy(lat, pre, 9);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'hFFFF_FF9C;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        if (data_resultRDY) pre++;
        wait_rdy(lat, pulses, 80);
        check("abort_pulses", 32'(pre + pulses), 32'd1);
        check("abort_lat", 32'(lat), 32'(DIV_LAT));
        check("abort_res", data_result, 32'hFFFF_FFF2);

        // Asynchronous reset in the middle of a divide.
        start(1'b1, 32'd1000, 32'd3);
        repeat (15) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_res", data_result, 32'd0);
        check("arst_exc", {31'd0, data_exception}, 32'd0);
        check("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("arst_addy", add_y, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_rdy(lat, pulses, 40);
        check("arst_norddy", 32'(pulses), 32'd0);
        run_op("mul_3x3", 1'b0, 32'd3, 32'd3, MUL_LAT, 32'd9, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
